pong_ball_engine: RTL and testbench
===================================

Name: pong_ball_engine

Overview:
Frame-rate game-logic stage directly upstream of the pong renderer. It advances the ball once per video frame, reflects it off the walls and the paddle, detects misses, and keeps a BCD score and a lives count. Outputs are ball_x/ball_y in active-area pixel coordinates (renderer adds back-porch offsets) and a 4-digit BCD score that feeds the 7-segment digit registers.

Parameters:
SCREEN_W, 640, active width in pixels
SCREEN_H, 480, active height in pixels
BALL_SIZE, 10, ball edge length in pixels
PADDLE_X, 0, paddle left edge x
PADDLE_W, 50, paddle width
PADDLE_H, 100, paddle height
SPEED, 1, pixels per frame on each axis
SERVE_DELAY, 60, frames parked before play resumes
LIVES_INIT, 3, lives at game start (1..7)

Ports:
clk50  in  1  system clock
reset  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (Vcounter==520 && Hcounter==0)
serve  in  1  debounced serve button, level; rising edge used
paddle_y  in  10  paddle top y, active coords
ball_x  out  10  ball left edge
ball_y  out  10  ball top edge
score  out  16  BCD score, [3:0] = ones digit
lives  out  3  remaining lives
miss  out  1  one-cycle pulse on miss
state  out  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4

Behaviour:
- One clock (clk50); reset is asynchronous and active-low (reset). All state async-cleared, no clock needed.
- Reset values: ball_x=(SCREEN_W-BALL_SIZE)/2=315, ball_y=(SCREEN_H-BALL_SIZE)/2=235, dx=+ (right), dy=+ (down), score=0x0000, lives=LIVES_INIT, miss=0, state=IDLE, serve-edge register=0, frame counter=0.
- Legal ranges: x in [XMIN=PADDLE_X+PADDLE_W, XMAX=SCREEN_W-BALL_SIZE]; y in [0, YMAX=SCREEN_H-BALL_SIZE].
- Serve edge: serve_q registered every cycle; rise = serve & ~serve_q. Evaluated every cycle, not only on frame_tick.
- IDLE: ball parked at centre; rise -> SERVE, frame counter=0.
- SERVE: ball held at centre, dx=+, dy=+. Counter increments on each frame_tick; when counter == SERVE_DELAY-1 on a frame_tick -> PLAY (SERVE lasts exactly SERVE_DELAY frames).
- PLAY: updates only on the frame_tick cycle; outputs registered, visible the cycle after frame_tick.
  - Y: ny = y±SPEED. If ny<=0 clamp 0, dy=+; if ny>=YMAX clamp YMAX, dy=-. Compute in 11-bit signed to avoid underflow.
  - X right: nx>=XMAX clamp XMAX, dx=-.
  - X left: if nx<=XMIN: hit when (ny+BALL_SIZE > paddle_y) && (ny < paddle_y+PADDLE_H); hit -> x=XMIN, dx=+, score BCD +1 with ripple carry, 9999 wraps to 0000. No hit -> MISS; ball position not updated that tick.
  - X and Y reflections in the same tick are both applied (corner).
- MISS (one cycle): miss=1, lives-=1, ball recentered; lives after decrement ==0 -> OVER else SERVE (counter=0).
- OVER: ball parked at centre, score held; rise -> score=0, lives=LIVES_INIT, SERVE.
- serve ignored in SERVE/PLAY/MISS. frame_tick outside SERVE/PLAY ignored.
- Reset assertion mid-PLAY returns to IDLE with reset values; score lost.

Optional Feature:
PONG_SPEEDUP_EN: defined -> 3-bit hit counter; every 8th paddle hit increments effective speed by 1 up to 4; speed returns to SPEED on entering SERVE. Undefined -> speed constant SPEED, no counter logic.

Test Plan:
- Reset low mid-operation, no clock -> ball (315,235), score 0x0000, lives 3, state IDLE immediately.
- serve rise, SERVE_DELAY=2 -> state PLAY after 2nd frame_tick; next tick ball (316,236).
- Ball y=469, dy=+ in PLAY, frame_tick -> y=470, dy=-; next tick y=469.
- Ball x=51, dx=-, y=240, paddle_y=200, frame_tick -> x=50, dx=+, score 0x0001; 10 such hits from 0x0009 path -> 0x0010.
- Same with paddle_y=400 -> miss pulse exactly 1 cycle, lives 3->2, state SERVE, ball (315,235).
- lives=1 miss -> state OVER; serve rise -> score 0x0000, lives 3, state SERVE.

Source files
------------

// File: rtl/pong_ball_engine_if.sv
// pong_ball_engine_if: frame-tick/serve/paddle inputs and ball/score/lives outputs of the pong ball engine.
interface pong_ball_engine_if;
  logic       frame_tick;
  logic       serve;
  logic [9:0] paddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [15:0] score;
  logic [2:0] lives;
  logic       miss;
  logic [2:0] state;
  modport master (output frame_tick, serve, paddle_y, input ball_x, ball_y, score, lives, miss, state);
  modport slave  (input frame_tick, serve, paddle_y, output ball_x, ball_y, score, lives, miss, state);
endinterface

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: per-frame ball motion, wall/paddle reflection, miss detection, BCD score and lives.
// Optional PONG_SPEEDUP_EN: every 8th paddle hit raises ball speed by one (max 4), reset on serve.
module pong_ball_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 10,
  parameter int PADDLE_X    = 0,
  parameter int PADDLE_W    = 50,
  parameter int PADDLE_H    = 100,
  parameter int SPEED       = 1,
  parameter int SERVE_DELAY = 60,
  parameter int LIVES_INIT  = 3
) (
  input logic clk50,
  input logic reset,
  pong_ball_engine_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, MISS = 3'd3, OVER = 3'd4;
  localparam logic [9:0] XC = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] YC = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic signed [11:0] S_XMIN = 12'(PADDLE_X + PADDLE_W);
  localparam logic signed [11:0] S_XMAX = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] S_YMAX = 12'(SCREEN_H - BALL_SIZE);
  logic [2:0]  r_state;
  logic [9:0]  r_x, r_y;
  logic        r_dx, r_dy;
  logic [15:0] r_score;
  logic [2:0]  r_lives;
  logic        r_serve_q;
  logic [15:0] r_cnt;
  logic        w_rise;
  logic [2:0]  w_spd;
  logic signed [11:0] w_sp, w_ny, w_nx, w_nyc, w_nxc, w_pad;
  logic        w_y_lo, w_y_hi, w_x_lo, w_x_hi, w_hit, w_bump, w_lost, w_carry;
  logic [15:0] w_score_inc;
  assign w_rise = bus.serve & ~r_serve_q;
  assign w_sp   = signed'({9'd0, w_spd});
  // 12-bit signed so a step below zero stays negative instead of wrapping
  assign w_ny   = r_dy ? signed'({2'b00, r_y}) + w_sp : signed'({2'b00, r_y}) - w_sp;
  assign w_nx   = r_dx ? signed'({2'b00, r_x}) + w_sp : signed'({2'b00, r_x}) - w_sp;
  assign w_y_lo = w_ny <= 12'sd0;
  assign w_y_hi = w_ny >= S_YMAX;
  assign w_nyc  = w_y_lo ? 12'sd0 : w_y_hi ? S_YMAX : w_ny;
  assign w_x_hi = r_dx && (w_nx >= S_XMAX);
  assign w_x_lo = !r_dx && (w_nx <= S_XMIN);
  assign w_nxc  = w_x_hi ? S_XMAX : w_x_lo ? S_XMIN : w_nx;
  assign w_pad  = signed'({2'b00, bus.paddle_y});
  assign w_hit  = (w_nyc + 12'(BALL_SIZE) > w_pad) && (w_nyc < w_pad + 12'(PADDLE_H));
  assign w_bump = w_x_lo && w_hit;
  assign w_lost = w_x_lo && !w_hit;
  always_comb begin
    w_score_inc = r_score;
    w_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        w_score_inc[4*i +: 4] = (r_score[4*i +: 4] == 4'd9) ? 4'd0 : r_score[4*i +: 4] + 4'd1;
        w_carry = (r_score[4*i +: 4] == 4'd9);
      end
    end
  end
`ifdef PONG_SPEEDUP_EN
  logic [2:0] r_hits, r_spd;
  always_ff @(posedge clk50 or negedge reset)
    if (!reset) begin
      r_hits <= 3'd0;
      r_spd  <= 3'(SPEED);
    end else if (r_state == SERVE) begin
      r_hits <= 3'd0;
      r_spd  <= 3'(SPEED);
    end else if (r_state == PLAY && bus.frame_tick && w_bump) begin
      r_hits <= r_hits + 3'd1;
      r_spd  <= (r_hits == 3'd7 && r_spd < 3'd4) ? r_spd + 3'd1 : r_spd;
    end
  assign w_spd = r_spd;
`else
  assign w_spd = 3'(SPEED);
`endif
  always_ff @(posedge clk50 or negedge reset)
    if (!reset) begin
      r_state   <= IDLE;
      r_x       <= XC;
      r_y       <= YC;
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
      r_score   <= 16'h0000;
      r_lives   <= 3'(LIVES_INIT);
      r_serve_q <= 1'b0;
      r_cnt     <= 16'd0;
    end else begin
      r_serve_q <= bus.serve;
      case (r_state)
        IDLE: if (w_rise) begin
          r_state <= SERVE;
          r_cnt   <= 16'd0;
        end
        SERVE: begin
          r_x  <= XC;
          r_y  <= YC;
          r_dx <= 1'b1;
          r_dy <= 1'b1;
          if (bus.frame_tick) begin
            r_state <= (r_cnt == 16'(SERVE_DELAY - 1)) ? PLAY : SERVE;
            r_cnt   <= r_cnt + 16'd1;
          end
        end
        PLAY: if (bus.frame_tick) begin
          if (w_lost) r_state <= MISS;
          else begin
            r_x     <= 10'(w_nxc);
            r_y     <= 10'(w_nyc);
            r_dx    <= w_x_hi ? 1'b0 : w_x_lo ? 1'b1 : r_dx;
            r_dy    <= w_y_lo ? 1'b1 : w_y_hi ? 1'b0 : r_dy;
            r_score <= w_bump ? w_score_inc : r_score;
          end
        end
        MISS: begin
          r_lives <= r_lives - 3'd1;
          r_x     <= XC;
          r_y     <= YC;
          r_cnt   <= 16'd0;
          r_state <= (r_lives == 3'd1) ? OVER : SERVE;
        end
        OVER: if (w_rise) begin
          r_score <= 16'h0000;
          r_lives <= 3'(LIVES_INIT);
          r_cnt   <= 16'd0;
          r_state <= SERVE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.ball_x = r_x;
  assign bus.ball_y = r_y;
  assign bus.score  = r_score;
  assign bus.lives  = r_lives;
  assign bus.miss   = (r_state == MISS);
  assign bus.state  = r_state;
endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: cycle-level reference model feeding a scoreboard, plus directed checkpoints.
module tb_pong_ball_engine;
  localparam int SD = 2;
  logic clk50 = 0, reset = 1, clk_en = 1;
  pong_ball_engine_if bus();
  pong_ball_engine #(.SERVE_DELAY(SD)) dut (.clk50(clk50), .reset(reset), .bus(bus));
  always #5 if (clk_en) clk50 = ~clk50;
  int n_cmp = 0, n_bad = 0;
  logic [42:0] sb_q[$];
  logic [42:0] obs;
  int m_st, m_x, m_y, m_dx, m_dy, m_score, m_lives, m_cnt;
  bit m_sq, chase;
  assign obs = {bus.state, bus.ball_x, bus.ball_y, bus.score, bus.lives, bus.miss};
  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic logic [42:0] exp_vec();
    return {3'(m_st), 10'(m_x), 10'(m_y), to_bcd(m_score), 3'(m_lives), m_st == 3};
  endfunction
  task automatic check(string tag, logic [42:0] got, logic [42:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_x = 315; m_y = 235; m_dx = 1; m_dy = 1;
    m_score = 0; m_lives = 3; m_cnt = 0; m_sq = 0;
  endtask
  task automatic model_step(bit tick, bit srv, int pad);
    int nx, ny, ndx, ndy;
    bit lost, rise;
    rise = srv && !m_sq;
    m_sq = srv;
    case (m_st)
      0: if (rise) begin m_st = 1; m_cnt = 0; end
      1: begin
        m_x = 315; m_y = 235; m_dx = 1; m_dy = 1;
        if (tick) begin
          if (m_cnt == SD - 1) m_st = 2;
          m_cnt++;
        end
      end
      2: if (tick) begin
        ny = m_y + m_dy; ndy = m_dy;
        if (ny <= 0) begin ny = 0; ndy = 1; end
        else if (ny >= 470) begin ny = 470; ndy = -1; end
        nx = m_x + m_dx; ndx = m_dx; lost = 0;
        if (m_dx > 0 && nx >= 630) begin nx = 630; ndx = -1; end
        else if (m_dx < 0 && nx <= 50) begin
          if (ny + 10 > pad && ny < pad + 100) begin
            nx = 50; ndx = 1; m_score = (m_score + 1) % 10000;
          end else lost = 1;
        end
        if (lost) m_st = 3;
        else begin m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy; end
      end
      3: begin
        m_lives--; m_x = 315; m_y = 235; m_cnt = 0;
        m_st = (m_lives == 0) ? 4 : 1;
      end
      4: if (rise) begin m_score = 0; m_lives = 3; m_cnt = 0; m_st = 1; end
      default: ;
    endcase
  endtask
  task automatic cycle(bit tick, bit srv);
    int pad;
    pad = chase ? (m_y > 20 ? m_y - 20 : 0) : (m_y < 240 ? 380 : 0);
    bus.frame_tick = tick;
    bus.serve = srv;
    bus.paddle_y = 10'(pad);
    model_step(tick, srv, pad);
    sb_q.push_back(exp_vec());
    @(negedge clk50);
    check("cyc", obs, sb_q.pop_front());
  endtask
  task automatic frame();
    cycle(1, 0);
    cycle(0, 0);
  endtask
  initial begin
    bus.frame_tick = 0;
    bus.serve = 0;
    bus.paddle_y = 0;
    chase = 1;
    model_reset();
    #1 reset = 0;
    #1 check("reset_vals", obs, {3'd0, 10'd315, 10'd235, 16'h0000, 3'd3, 1'b0});
    @(negedge clk50);
    reset = 1;
    cycle(0, 0);
    cycle(0, 1);
    check("serve_state", 43'(bus.state), 43'(3'd1));
    cycle(0, 1);
    cycle(0, 0);
    frame();
    check("serve_hold", {bus.state, bus.ball_x, bus.ball_y}, {3'd1, 10'd315, 10'd235});
    frame();
    check("play_after_2", 43'(bus.state), 43'(3'd2));
    frame();
    check("first_move", {bus.ball_x, bus.ball_y}, {10'd316, 10'd236});
    for (int k = 0; k < 15000 && m_score < 10; k++) frame();
    check("score_0010", 43'(bus.score), 43'(16'h0010));
    chase = 0;
    for (int k = 0; k < 3000 && m_lives == 3; k++) frame();
    check("after_miss", {bus.state, bus.ball_x, bus.ball_y, bus.lives, bus.miss},
          {3'd1, 10'd315, 10'd235, 3'd2, 1'b0});
    for (int k = 0; k < 3000 && m_st != 4; k++) frame();
    check("game_over", {bus.state, bus.lives, bus.score}, {3'd4, 3'd0, 16'h0010});
    cycle(0, 0);
    cycle(0, 1);
    check("restart", {bus.state, bus.score, bus.lives}, {3'd1, 16'h0000, 3'd3});
    cycle(0, 0);
    for (int k = 0; k < 6; k++) frame();
    check("replay", {bus.state, bus.ball_x, bus.ball_y}, {3'd2, 10'd319, 10'd239});
    clk_en = 0;
    #3 reset = 0;
    model_reset();
    #1 check("async_reset", obs, exp_vec());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
